// File: rtl/gb_pkg.sv
// Shared definitions for the ghostbus host adapter: FSM encoding and the
// read-latency counter type.
package gb_pkg;

  localparam int LAT_CNT_W = 4;

  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } gb_state_e;

endpackage

// File: rtl/gb_host_adapter_if.sv
// Host-side command/response channel of the ghostbus adapter.
// The master modport is the host; the slave modport is the adapter.
interface gb_host_adapter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/gb_host_adapter.sv
// Bridges a valid/ready host command channel onto the ghostbus: posted
// single-cycle writes and fixed-latency reads returned on a response channel.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a command; writes issue without leaving this state
// ST_RD_WAIT | gb_re issued, counting down RD_LAT until gb_rdata is valid
// ST_RSP     | read data held on rsp_rdata until the host takes it
module gb_host_adapter
  import gb_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gb_host_adapter_if.slave      host,
  output logic [AW-1:0]         gb_addr,
  output logic [DW-1:0]         gb_wdata,
  output logic                  gb_we,
  output logic                  gb_re,
  input  logic [DW-1:0]         gb_rdata,
  output logic [15:0]           wr_count
);

  gb_state_e     r_state;
  gb_state_e     w_state_nxt;
  lat_cnt_t      r_lat_cnt;
  lat_cnt_t      w_lat_cnt_nxt;
  logic          w_issue_wr;
  logic          w_issue_rd;
  logic          w_sample;

  logic [AW-1:0] r_gb_addr;
  logic [DW-1:0] r_gb_wdata;
  logic          r_gb_we;
  logic          r_gb_re;
  logic [DW-1:0] r_rsp_rdata;
  logic [15:0]   r_wr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lat_cnt_nxt  = r_lat_cnt;
    w_issue_wr     = 1'b0;
    w_issue_rd     = 1'b0;
    w_sample       = 1'b0;
    host.cmd_ready = (r_state == ST_IDLE);
    host.rsp_valid = (r_state == ST_RSP);
    case (r_state)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          if (host.cmd_we) begin
            w_issue_wr = 1'b1;
          end else begin
            w_issue_rd    = 1'b1;
            w_lat_cnt_nxt = lat_cnt_t'(RD_LAT);
            w_state_nxt   = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // Counter hits zero on the cycle gb_rdata is RD_LAT cycles past gb_re.
        if (r_lat_cnt == '0) begin
          w_sample    = 1'b1;
          w_state_nxt = ST_RSP;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - lat_cnt_t'(1);
        end
      end
      ST_RSP: begin
        if (host.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gb_addr   <= '0;
      r_gb_wdata  <= '0;
      r_gb_we     <= 1'b0;
      r_gb_re     <= 1'b0;
      r_rsp_rdata <= '0;
      r_wr_count  <= '0;
    end else begin
      r_gb_we <= w_issue_wr;
      r_gb_re <= w_issue_rd;
      if (w_issue_wr || w_issue_rd) r_gb_addr <= host.cmd_addr;
      if (w_issue_wr) begin
        r_gb_wdata <= host.cmd_wdata;
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_sample) r_rsp_rdata <= gb_rdata;
    end
  end

  assign gb_addr        = r_gb_addr;
  assign gb_wdata       = r_gb_wdata;
  assign gb_we          = r_gb_we;
  assign gb_re          = r_gb_re;
  assign wr_count       = r_wr_count;
  assign host.rsp_rdata = r_rsp_rdata;

endmodule
